// File: rtl/board_gen_pkg.sv
// Shared types and constants for the Memory Matrix board generator.
package board_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_e;

  localparam int unsigned BOARD_W   = 8;
  localparam int unsigned MAX_TILES = 8;
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Requested tile count mapped into 1..MAX_TILES.
  function automatic logic [3:0] clamp_tiles(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'(MAX_TILES)) return 4'(MAX_TILES);
    return n;
  endfunction

endpackage

// File: rtl/board_generator_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left; a zero SEED becomes 1.
module lfsr16
  import board_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] q
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED_EFF;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/board_generator.sv
// Builds an 8-tile solution board with exactly K lit tiles, one tile per GEN cycle.
// Macro BOARD_GEN_FIXED_SEED_EN: LFSR advances only in GEN (repeatable boards).
module board_generator
  import board_gen_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned BOARD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         tile_count,
  input  logic               board_ack,
  output logic [BOARD_W-1:0] board,
  output logic               board_valid,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         k_q, k_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [15:0] lfsr_q;
  logic        lfsr_adv;
  logic        lfsr_hi_unused;
  logic [2:0]  cand, slot, idx;
  logic        found;

`ifdef BOARD_GEN_FIXED_SEED_EN
  assign lfsr_adv = (state_q == GEN);
`else
  assign lfsr_adv = 1'b1;
`endif

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  assign lfsr_hi_unused = ^lfsr_q[15:3];
  assign cand = lfsr_q[2:0];

  // Probe the candidate tile, then walk forward (mod 8) to the first dark tile.
  always_comb begin
    slot  = cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < BOARD_W; i++) begin
      idx = cand + 3'(i);
      if (!found && !board_q[idx]) begin
        slot  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = GEN;
          k_d     = clamp_tiles(tile_count);
          board_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end else if (state_q == DONE && board_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      GEN: begin
        board_d[slot] = 1'b1;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_d == k_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign board       = board_q;
  assign board_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_board_generator.sv
// Self-checking bench for board_generator against a behavioural board model.
module tb_board_generator;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] tile_count = 4'd0;
  logic       board_ack = 1'b0;
  logic [7:0] board;
  logic       board_valid;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  exp_board;
  int          exp_k;

  board_generator #(.SEED(SEED), .BOARD_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .tile_count  (tile_count),
    .board_ack   (board_ack),
    .board       (board),
    .board_valid (board_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int clamp_k(input int n);
    return (n == 0) ? 1 : (n > 8 ? 8 : n);
  endfunction

  // Board that K placements from LFSR state l produce.
  function automatic logic [7:0] model_board(input logic [15:0] l, input int k);
    logic [7:0] b = 8'h00;
    logic [15:0] s = l;
    for (int t = 0; t < k; t++) begin
      int c = int'(s[2:0]);
      for (int j = 0; j < 8; j++) begin
        if (!b[(c + j) % 8]) begin
          b[(c + j) % 8] = 1'b1;
          break;
        end
      end
      s = step(s);
    end
    return b;
  endfunction

`ifndef BOARD_GEN_FIXED_SEED_EN
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= step(m_lfsr);
  end
`endif

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
`ifdef BOARD_GEN_FIXED_SEED_EN
    m_lfsr = SEED;
`endif
  endtask

  // Drive an accepted start (optionally with ack) and record the expected board.
  task automatic do_start(input int n, input bit with_ack);
    @(negedge clk);
    start = 1'b1;
    tile_count = 4'(n);
    board_ack = with_ack;
    @(posedge clk);
    #1;
    start = 1'b0;
    board_ack = 1'b0;
    exp_k = clamp_k(n);
    exp_board = model_board(m_lfsr, exp_k);
`ifdef BOARD_GEN_FIXED_SEED_EN
    for (int i = 0; i < exp_k; i++) m_lfsr = step(m_lfsr);
`endif
  endtask

  // Observe one generation; lat = -1 on timeout.
  task automatic wait_done(input bit poke_start, output int lat, output int busy_n, output int overlap);
    lat = -1;
    busy_n = 0;
    overlap = 0;
    if (busy) busy_n++;
    if (busy && board_valid) overlap++;
    if (poke_start) begin
      start = 1'b1;
      tile_count = 4'd1;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy && board_valid) overlap++;
      if (board_valid) begin
        lat = c;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if (board !== 8'h00) begin miscompares++; $display("FAIL reset_board got %h want 00", board); end
    vectors++;
    if (board_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", board_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_tile_counts();
    int counts[5] = '{1, 2, 8, 0, 15};
    int lat, bn, ov;
    foreach (counts[i]) begin
      if (i < 2) apply_reset();
      do_start(counts[i], 1'b0);
      wait_done(1'b0, lat, bn, ov);
      vectors++;
      if (lat !== exp_k) begin miscompares++; $display("FAIL latency_k%0d got %0d want %0d", counts[i], lat, exp_k); end
      vectors++;
      if (bn !== exp_k) begin miscompares++; $display("FAIL busy_cycles_k%0d got %0d want %0d", counts[i], bn, exp_k); end
      vectors++;
      if (board !== exp_board) begin miscompares++; $display("FAIL board_k%0d got %h want %h", counts[i], board, exp_board); end
      vectors++;
      if ($countones(board) !== exp_k) begin miscompares++; $display("FAIL popcount_k%0d got %0d want %0d", counts[i], $countones(board), exp_k); end
      vectors++;
      if (ov !== 0) begin miscompares++; $display("FAIL overlap_k%0d got %0d want 0", counts[i], ov); end
    end
  endtask

  task automatic test_ack_retain();
    @(negedge clk) board_ack = 1'b1;
    @(posedge clk);
    #1 board_ack = 1'b0;
    vectors++;
    if (board_valid !== 1'b0) begin miscompares++; $display("FAIL ack_valid got %b want 0", board_valid); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (board !== exp_board) begin miscompares++; $display("FAIL idle_board got %h want %h", board, exp_board); end
    vectors++;
    if (busy !== 1'b0 || board_valid !== 1'b0) begin miscompares++; $display("FAIL idle_flags got busy=%b valid=%b want 0 0", busy, board_valid); end
    @(negedge clk) board_ack = 1'b1;
    @(posedge clk);
    #1 board_ack = 1'b0;
    vectors++;
    if (board_valid !== 1'b0 || board !== exp_board) begin miscompares++; $display("FAIL stray_ack got valid=%b board=%h want 0 %h", board_valid, board, exp_board); end
  endtask

  task automatic test_start_during_gen();
    int lat, bn, ov;
    do_start(5, 1'b0);
    wait_done(1'b1, lat, bn, ov);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL gen_start_latency got %0d want 5", lat); end
    vectors++;
    if (board !== exp_board) begin miscompares++; $display("FAIL gen_start_board got %h want %h", board, exp_board); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, ov;
    do_start(3, 1'b1);
    vectors++;
    if (board_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_flags got valid=%b busy=%b want 0 1", board_valid, busy); end
    wait_done(1'b0, lat, bn, ov);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL b2b_latency got %0d want 3", lat); end
    vectors++;
    if (board !== exp_board) begin miscompares++; $display("FAIL b2b_board got %h want %h", board, exp_board); end
  endtask

  task automatic test_reset_mid_gen();
    int lat, bn, ov;
    do_start(6, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (board !== 8'h00 || board_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midgen_reset got board=%h valid=%b busy=%b want 00 0 0", board, board_valid, busy);
    end
    @(negedge clk) reset = 1'b0;
`ifdef BOARD_GEN_FIXED_SEED_EN
    m_lfsr = SEED;
`endif
    do_start(4, 1'b0);
    wait_done(1'b0, lat, bn, ov);
    vectors++;
    if (board !== exp_board) begin miscompares++; $display("FAIL post_reset_board got %h want %h", board, exp_board); end
  endtask

  task automatic test_random();
    int lat, bn, ov;
    bit in_done = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      bit pair_ack = in_done && ($urandom_range(0, 1) == 1);
      if (!in_done) repeat ($urandom_range(0, 3)) @(posedge clk);
      do_start(int'($urandom_range(0, 15)), pair_ack);
      wait_done(1'b0, lat, bn, ov);
      vectors++;
      if (lat !== exp_k || ov !== 0) begin miscompares++; $display("FAIL rnd_timing it%0d got lat=%0d ov=%0d want %0d 0", it, lat, ov, exp_k); end
      vectors++;
      if ($countones(board) !== exp_k || board !== exp_board) begin
        miscompares++;
        $display("FAIL rnd_board it%0d got %h want %h (k=%0d)", it, board, exp_board, exp_k);
      end
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk);
        #1;
        vectors++;
        if (board !== exp_board || board_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL rnd_hold it%0d got board=%h valid=%b want %h 1", it, board, board_valid, exp_board);
        end
      end
      in_done = ($urandom_range(0, 9) < 3);
      if (!in_done) begin
        @(negedge clk) board_ack = 1'b1;
        @(posedge clk);
        #1 board_ack = 1'b0;
        vectors++;
        if (board_valid !== 1'b0 || board !== exp_board) begin
          miscompares++;
          $display("FAIL rnd_ack it%0d got valid=%b board=%h want 0 %h", it, board_valid, board, exp_board);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tile_counts();
    test_ack_retain();
    test_start_during_gen();
    test_back_to_back();
    test_reset_mid_gen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_generator.md
# board_generator

Produces the hidden solution pattern for each Memory Matrix round. On a start pulse it builds an 8-tile board with exactly the requested number of lit tiles, drawn from a 16-bit LFSR. It then presents the board with a valid/ack handshake. It sits directly upstream of the guess-checking and display datapath, which consume `board` as the solution board.

## Interface
Parameters:
- `SEED`, default `16'hACE1`: LFSR reset value. A value of 0 is replaced by `16'h0001`.
- `BOARD_W`, default 8: number of tiles. Fixed at 8; other values are unsupported.

Ports:
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request for a new board.
- `tile_count` in 4: number of lit tiles. 0 is treated as 1; values above 8 are clamped to 8.
- `board_ack` in 1: consumer has taken the board.
- `board` out 8: solution pattern, one bit per tile.
- `board_valid` out 1: `board` is complete and stable.
- `busy` out 1: generation is in progress.

## Operation
- States: IDLE, GEN, DONE.
- Reset: state IDLE, `board`=0, `board_valid`=0, `busy`=0, LFSR=`SEED`, tile counter=0.
- IDLE:
  - `start`=1 → GEN.
  - On the same edge: latch the clamped `tile_count` as K, clear `board`, clear the counter.
- GEN (`busy`=1), each cycle:
  - Candidate c = LFSR[2:0].
  - If `board[c]`=0, set it.
  - Otherwise set the first clear bit in the wrap order c+1, c+2, … c+7 (mod 8).
  - Increment the counter and advance the LFSR.
  - When the counter reaches K on this edge → DONE.
- DONE (`board_valid`=1):
  - `board_ack` → IDLE.
  - `start` → GEN, with the same actions as from IDLE. `start` has priority over `board_ack`.
- `start` during GEN is ignored; no queuing.
- `board_ack` outside DONE is ignored.
- `board` is unchanged from leaving GEN until the next accepted start, including through IDLE.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left each update; feedback = b15^b13^b12^b10, inserted at bit 0.
  - Never reaches zero.
- Invariant: on entering DONE, popcount(`board`) = K exactly.
- Reset asserted in any state overrides everything and returns to the reset values on the next edge.

## Timing
- Start sampled at edge T.
- GEN occupies edges T+1 … T+K, adding one tile per edge.
- `board_valid` is high from the cycle after edge T+K. Total latency from start is K+1 cycles (2 … 9).
- `busy` is high during GEN only.
- `busy` and `board_valid` are never high together.
- `board_valid` falls on the edge that samples `board_ack`.
- Back-to-back start from DONE drops `board_valid` on the same edge that enters GEN.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `BOARD_GEN_FIXED_SEED_EN` defined:
  - The LFSR advances only in GEN.
  - The board sequence depends solely on `SEED` and the sequence of K values, and is repeatable for simulation and demos.
- Not defined:
  - The LFSR advances every cycle in every state.
  - Boards then depend on when the player presses start.

## Structure
- `board_gen_pkg` holds:
  - the state enum;
  - `BOARD_W`=8;
  - `MAX_TILES`=8;
  - the LFSR width and tap mask `16'hB400`.
- Sub-module `lfsr16`:
  - ports `clk`, `reset`, `advance`, `q[15:0]`;
  - owns the seed-zero substitution.
- The probe and free-slot selection are combinational logic inside `board_generator`.

## Test plan
- Fixed seed, `SEED`=`16'hACE1`, `tile_count`=1, start → `board`=`8'h02`; `board_valid` rises 2 cycles after start; `busy` high for 1 cycle.
- Fixed seed, reset, `tile_count`=2, start → `board`=`8'h0A` (candidates from LFSR `ACE1`, then `59C3`).
- `tile_count`=8 → `board`=`8'hFF` after 9 cycles; `tile_count`=0 → exactly 1 bit set; `tile_count`=15 → `8'hFF`.
- Start pulsed during GEN → ignored, same latency. Start and `board_ack` together in DONE → new generation begins and `board_valid` drops. `board_ack` alone → IDLE with `board` retained.
- Reset asserted mid-GEN → next cycle `board`=0, `board_valid`=0, `busy`=0, LFSR=`SEED`.
- 1000 random starts with random `tile_count` and random ack delays (macro undefined) → popcount = clamped K every time; `board` stable throughout each `board_valid` window.
